pc_sequencer: RTL and testbench

Owns the program counter and sequences instruction fetch in the IF stage. Each cycle it picks the next fetch address from reset, exception, return-from-exception, an ID-stage redirect (the taken branch/jump/register target computed by the next-PC logic) or sequential PC+1. It drives a single-outstanding request/grant/response handshake to instruction memory and delivers instructions to the IF/ID latch. A one-entry hold buffer absorbs responses that arrive while the pipeline is stalled.

---
 rtl/pc_seq_pkg.sv | 17 +
 rtl/fetch_hold_buf.sv | 33 +++
 rtl/pc_sequencer.sv | 133 +++++++++++++
 tb/tb_pc_sequencer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
// Shared types and default constants for the IF-stage program counter sequencer.
// EXC_VEC_DEF is only consumed when PC_EXC_VEC_EN is defined.
package pc_seq_pkg;

  typedef logic [29:0] waddr_t;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DROP  = 2'd3
  } state_t;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] EXC_VEC_DEF  = 32'h0000_4180;

endpackage

// File: rtl/fetch_hold_buf.sv
// One-entry skid slot for a fetched instruction; write, read and flush take effect next edge.
// Flush beats write; writes are only issued while the slot is empty.
module fetch_hold_buf
  import pc_seq_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [29:0] wr_pc,
  input  logic [31:0] wr_instr,
  input  logic        rd,
  input  logic        flush,
  output logic        vld,
  output logic [29:0] pc,
  output logic [31:0] instr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld   <= 1'b0;
      pc    <= '0;
      instr <= '0;
    end else begin
      if (flush || rd) vld <= 1'b0;
      if (wr && !flush) begin
        vld   <= 1'b1;
        pc    <= wr_pc;
        instr <= wr_instr;
      end
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// IF-stage PC owner: single-outstanding imem fetch, IF/ID output register plus one-entry hold slot.
// Define PC_EXC_VEC_EN to enable exc_req/eret/epc and the EXC_VEC entry point.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] EXC_VEC  = EXC_VEC_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [29:0] redirect_npc,
  input  logic        exc_req,
  input  logic        eret,
  input  logic [29:0] epc,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [29:0] if_pc,
  output logic [31:0] if_instr
);

  localparam waddr_t RST_WA = RESET_PC[31:2];

  state_t state;
  waddr_t pc;
  waddr_t pend_pc;
  logic   drop;

  logic   redir;
  waddr_t redir_pc;

`ifdef PC_EXC_VEC_EN
  localparam waddr_t EXC_WA = EXC_VEC[31:2];

  always_comb begin
    redir    = exc_req | eret | redirect_valid;
    redir_pc = redirect_npc;
    if (exc_req)   redir_pc = EXC_WA;
    else if (eret) redir_pc = epc;
  end
`else
  logic unused_exc;
  assign unused_exc = ^{exc_req, eret, epc, EXC_VEC};
  assign redir      = redirect_valid;
  assign redir_pc   = redirect_npc;
`endif

  logic        hb_vld;
  logic [29:0] hb_pc;
  logic [31:0] hb_instr;
  logic        hb_wr;
  logic        hb_rd;
  logic        rsp_ok;
  logic        direct;
  logic        grant;

  // A response coinciding with a redirect belongs to the abandoned path.
  assign rsp_ok = (state == WAIT) && imem_rvalid && !drop && !redir;
  assign direct = rsp_ok && !stall && !hb_vld;
  assign hb_wr  = rsp_ok && !direct;
  assign hb_rd  = hb_vld && !stall && !redir;

  // Back-to-back fetch: the next request may go out alongside a directly presented response.
  assign imem_req  = ((state == ISSUE) && !hb_vld) || direct;
  assign imem_addr = pc;
  assign grant     = imem_req && imem_gnt;

  fetch_hold_buf u_hold (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr       (hb_wr),
    .wr_pc    (pend_pc),
    .wr_instr (imem_rdata),
    .rd       (hb_rd),
    .flush    (redir),
    .vld      (hb_vld),
    .pc       (hb_pc),
    .instr    (hb_instr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RST_WA;
      pend_pc  <= '0;
      drop     <= 1'b0;
      if_valid <= 1'b0;
      if_pc    <= '0;
      if_instr <= '0;
    end else begin
      if (!(if_valid && stall)) begin
        if_valid <= hb_rd || direct;
        if (hb_rd) begin
          if_pc    <= hb_pc;
          if_instr <= hb_instr;
        end else if (direct) begin
          if_pc    <= pend_pc;
          if_instr <= imem_rdata;
        end
      end

      if (redir)      pc <= redir_pc;
      else if (grant) pc <= pc + 30'd1;
      if (grant) pend_pc <= pc;

      case (state)
        BOOT:  state <= ISSUE;
        ISSUE: if (grant) begin
          state <= WAIT;
          drop  <= redir;
        end
        WAIT: if (imem_rvalid) begin
          drop  <= 1'b0;
          state <= grant ? WAIT : ISSUE;
        end else if (redir) begin
          drop  <= 1'b1;
          state <= DROP;
        end
        DROP: if (imem_rvalid) begin
          drop  <= 1'b0;
          state <= ISSUE;
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed literal checks plus a randomized run against a fetch-stream model.
module tb_pc_sequencer;

  localparam logic [29:0] RST_WA = 30'h0C00;
  localparam logic [29:0] EXC_WA = 30'h1060;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall;
  logic        redirect_valid;
  logic [29:0] redirect_npc;
  logic        exc_req;
  logic        eret;
  logic [29:0] epc;
  logic        imem_req;
  logic [29:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [29:0] if_pc;
  logic [31:0] if_instr;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int deliveries = 0;
  int gnt_pct = 100;
  int lat_max = 1;

  typedef struct {
    logic [29:0] a;
    int          due;
  } mreq_t;
  mreq_t mq[$];

  logic [29:0] exp_fetch;
  logic [29:0] exp_pc;
  logic        prev_held;
  logic [29:0] prev_pc;
  logic [31:0] prev_instr;
  logic        m_redir;
  logic [29:0] m_tgt;

  pc_sequencer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_npc   (redirect_npc),
    .exc_req        (exc_req),
    .eret           (eret),
    .epc            (epc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_instr       (if_instr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk_instr(input logic [29:0] a);
    return {a, 2'b01} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, return at the falling edge.
  task automatic step(input logic st, input logic rd = 1'b0, input logic [29:0] npc = '0,
                      input logic ex = 1'b0, input logic er = 1'b0, input logic [29:0] ep = '0);
    @(posedge clk);
    #1;
    stall          = st;
    redirect_valid = rd;
    redirect_npc   = npc;
    exc_req        = ex;
    eret           = er;
    epc            = ep;
    imem_gnt       = ($urandom_range(99) < gnt_pct);
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mk_instr(mq[0].a);
      void'(mq.pop_front());
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    #4;
  endtask

  // Model: the granted address stream and the delivered stream are each sequential,
  // restarting at the redirect target chosen by priority.
  always_comb begin
    m_redir = redirect_valid;
    m_tgt   = redirect_npc;
`ifdef PC_EXC_VEC_EN
    m_redir = exc_req | eret | redirect_valid;
    if (exc_req)   m_tgt = EXC_WA;
    else if (eret) m_tgt = epc;
`endif
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_fetch = RST_WA;
      exp_pc    = RST_WA;
      prev_held = 1'b0;
      mq.delete();
    end else begin
      if (prev_held) begin
        chk("stalled_valid", if_valid, 1'b1);
        chk("stalled_pc", if_pc, prev_pc);
        chk("stalled_instr", if_instr, prev_instr);
      end else if (if_valid) begin
        chk("deliver_pc", if_pc, exp_pc);
        chk("deliver_instr", if_instr, mk_instr(if_pc));
        exp_pc = exp_pc + 30'd1;
        deliveries++;
      end
      prev_held  = if_valid && stall;
      prev_pc    = if_pc;
      prev_instr = if_instr;

      if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        chk("one_outstanding", 32'(mq.size()), 0);
        exp_fetch = exp_fetch + 30'd1;
        mq.push_back('{imem_addr, cyc + int'($urandom_range(lat_max, 1))});
      end

      if (m_redir) begin
        exp_fetch = m_tgt;
        exp_pc    = m_tgt;
      end
    end
    cyc++;
  end

  initial begin
    rst_n = 1'b0; stall = 1'b0; redirect_valid = 1'b0; redirect_npc = '0;
    exc_req = 1'b0; eret = 1'b0; epc = '0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_addr", imem_addr, 30'h0C00);
    chk("rst_if_valid", if_valid, 0);
    chk("rst_if_pc", if_pc, 0);
    chk("rst_if_instr", if_instr, 0);

    @(posedge clk); #1 rst_n = 1'b1; imem_gnt = 1'b1; #4;
    chk("boot_req", imem_req, 0);

    step(0); chk("addr0", imem_addr, 30'h0C00); chk("addr0_req", imem_req, 1);
    step(0); chk("addr1", imem_addr, 30'h0C01);
    step(0); chk("addr2", imem_addr, 30'h0C02); chk("first_pc", if_pc, 30'h0C00);
    chk("first_valid", if_valid, 1);
    step(0);
    step(0);
    step(0); chk("addr5", imem_addr, 30'h0C05);
    step(0, 1'b1, 30'h1234); chk("pre_redir_pc", if_pc, 30'h0C04);
    step(0); chk("redir_addr", imem_addr, 30'h1234); chk("c05_dropped", if_valid, 0);
    step(0); chk("redir_gap", if_valid, 0);
    step(0); chk("redir_pc", if_pc, 30'h1234); chk("redir_valid", if_valid, 1);

    step(1); chk("stall_pc0", if_pc, 30'h1235);
    step(1); chk("full_no_req", imem_req, 0);
    step(1); chk("stall_pc2", if_pc, 30'h1235); chk("stall_valid", if_valid, 1);
    step(0); chk("free_no_req", imem_req, 0);
    step(0); chk("resume_pc", if_pc, 30'h1236); chk("resume_addr", imem_addr, 30'h1237);
    step(0);
    step(0, 1'b1, 30'h3FFF_FFFF); chk("pre_wrap_pc", if_pc, 30'h1237);
    step(0); chk("wrap_top", imem_addr, 30'h3FFF_FFFF);
    step(0); chk("wrap_zero", imem_addr, 30'h0000_0000);
    step(0); chk("wrap_pc_top", if_pc, 30'h3FFF_FFFF);
    step(0, 1'b1, 30'h5555, 1'b1); chk("wrap_pc_zero", if_pc, 30'h0);
    step(0);
`ifdef PC_EXC_VEC_EN
    chk("exc_addr", imem_addr, 30'h1060);
`else
    chk("exc_ignored", imem_addr, 30'h5555);
`endif
    step(0);
    step(0, 1'b0, '0, 1'b0, 1'b1, 30'h0C10);
    step(0);
`ifdef PC_EXC_VEC_EN
    chk("eret_addr", imem_addr, 30'h0C10);
`endif

    gnt_pct = 70;
    lat_max = 3;
    for (int i = 0; i < 3000; i++) begin
      logic [29:0] tgt;
      tgt = ($urandom_range(3) == 0) ? 30'h3FFF_FFFE : 30'($urandom);
      step($urandom_range(99) < 25, $urandom_range(99) < 6, tgt,
           $urandom_range(99) < 3, $urandom_range(99) < 3, 30'($urandom));
    end

    gnt_pct = 100;
    begin
      int k;
      k = 0;
      do begin
        step(0);
        k++;
      end while (!(imem_req && imem_gnt) && k < 50);
      chk("reach_wait", k < 50, 1);
    end
    @(posedge clk); #1 rst_n = 1'b0; imem_rvalid = 1'b0; #4;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_addr", imem_addr, 30'h0C00);
    chk("mid_rst_valid", if_valid, 0);
    chk("mid_rst_pc", if_pc, 0);
    lat_max = 1;
    @(posedge clk); #1 rst_n = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF; #4;
    chk("reboot_req", imem_req, 0);
    step(0); chk("reboot_addr", imem_addr, 30'h0C00); chk("stray_ignored", if_valid, 0);
    step(0);
    step(0); chk("reboot_pc", if_pc, 30'h0C00); chk("reboot_instr", if_instr, mk_instr(30'h0C00));
    repeat (5) step(0);

    chk("liveness", deliveries > 200, 1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
